// File: rtl/udp_status_sender_if.sv
// Byte stream from the status sender into the liteeth UDP port sink.
// The sender is the master; liteeth_core is the slave and owns ready.
interface udp_status_sender_if;
  logic       valid;
  logic       last;
  logic       ready;
  logic [7:0] data;

  modport master (output valid, output last, output data, input ready);
  modport slave  (input valid, input last, input data, output ready);
endinterface

// File: rtl/udp_status_sender.sv
// udp_status_sender: queues acknowledge requests and serialises each one as a
// fixed 12-byte status payload onto the liteeth udp0_sink byte stream. Emits
// heartbeat packets (status 0xFF, seq 0x0000) after a run of idle cycles.
//
// Payload: 4C 43 01 status seq[15:8] seq[7:0] tx[31:24..7:0] drop[15:8..7:0]
module udp_status_sender #(
  parameter int FIFO_DEPTH       = 4,
  parameter int HEARTBEAT_CYCLES = 125000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ack_req,
  input  logic [15:0]         ack_seq,
  input  logic [7:0]          ack_status,
  udp_status_sender_if.master udp0_sink,
  output logic                busy
);

  localparam int              PTR_W       = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  DEPTH_VAL   = FIFO_DEPTH[PTR_W:0];
  localparam bit              HB_EN       = (HEARTBEAT_CYCLES != 0);
  localparam int              HB_W        = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
  localparam int              HB_LAST_INT = (HEARTBEAT_CYCLES > 0) ? HEARTBEAT_CYCLES - 1 : 0;
  localparam logic [HB_W-1:0] HB_LAST     = HB_LAST_INT[HB_W-1:0];

  localparam logic [7:0] MAGIC_0   = 8'h4C;
  localparam logic [7:0] MAGIC_1   = 8'h43;
  localparam logic [7:0] VERSION   = 8'h01;
  localparam logic [7:0] HB_STATUS = 8'hFF;
  localparam logic [3:0] LAST_IDX  = 4'd11;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t           state;

  // Request queue: {seq, status} per entry
  logic [23:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  // Running counters
  logic [15:0]      drop_count;
  logic [31:0]      tx_count;
  logic [HB_W-1:0]  hb_count;

  // Fields of the packet currently being sent
  logic [15:0]      pkt_seq;
  logic [7:0]       pkt_status;
  logic [31:0]      pkt_tx;
  logic [15:0]      pkt_drop;
  logic [3:0]       byte_idx;
  logic [3:0]       next_idx;
  logic [7:0]       next_byte;

  assign fifo_full  = (fifo_count == DEPTH_VAL);
  assign fifo_empty = (fifo_count == '0);
  // Fullness is judged before the edge, so a same-cycle pop never rescues a request.
  assign push       = ack_req & ~fifo_full;
  assign pop        = (state == LOAD) & ~fifo_empty;

  // Queue storage write port.
  // NOTE: storage has no reset; fifo_count gates every read, so stale entries are never used.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {ack_seq, ack_status};
    end
  end

  // Payload byte that follows the one currently on the bus.
  // NOTE: next_byte gets a default before the case so no latch is inferred.
  always_comb begin
    next_idx  = byte_idx + 4'd1;
    next_byte = 8'h00;
    case (next_idx)
      4'd1:    next_byte = MAGIC_1;
      4'd2:    next_byte = VERSION;
      4'd3:    next_byte = pkt_status;
      4'd4:    next_byte = pkt_seq[15:8];
      4'd5:    next_byte = pkt_seq[7:0];
      4'd6:    next_byte = pkt_tx[31:24];
      4'd7:    next_byte = pkt_tx[23:16];
      4'd8:    next_byte = pkt_tx[15:8];
      4'd9:    next_byte = pkt_tx[7:0];
      4'd10:   next_byte = pkt_drop[15:8];
      4'd11:   next_byte = pkt_drop[7:0];
      default: next_byte = 8'h00;
    endcase
  end

  // Control FSM, queue pointers, counters and all registered outputs.
  // NOTE: non-blocking assignments throughout, so every decision uses pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_count      <= '0;
      drop_count      <= '0;
      tx_count        <= '0;
      hb_count        <= '0;
      pkt_seq         <= '0;
      pkt_status      <= '0;
      pkt_tx          <= '0;
      pkt_drop        <= '0;
      byte_idx        <= '0;
      udp0_sink.valid <= 1'b0;
      udp0_sink.last  <= 1'b0;
      udp0_sink.data  <= 8'h00;
      busy            <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      if (ack_req && fifo_full && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end

      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state    <= LOAD;
            hb_count <= '0;
            busy     <= 1'b1;
          end else if (HB_EN && (hb_count == HB_LAST)) begin
            state    <= LOAD;
            hb_count <= '0;
            busy     <= 1'b1;
          end else begin
            if (HB_EN) begin
              hb_count <= hb_count + 1'b1;
            end
            busy <= push;
          end
        end

        // Decide request vs heartbeat here: a request that landed during the
        // heartbeat expiry cycle is already queued and wins.
        LOAD: begin
          if (!fifo_empty) begin
            {pkt_seq, pkt_status} <= fifo_mem[rd_ptr];
          end else begin
            pkt_seq    <= 16'h0000;
            pkt_status <= HB_STATUS;
          end
          pkt_tx          <= tx_count;
          pkt_drop        <= drop_count;
          byte_idx        <= '0;
          udp0_sink.valid <= 1'b1;
          udp0_sink.data  <= MAGIC_0;
          udp0_sink.last  <= 1'b0;
          busy            <= 1'b1;
          state           <= SEND;
        end

        SEND: begin
          if (udp0_sink.ready) begin
            if (byte_idx == LAST_IDX) begin
              udp0_sink.valid <= 1'b0;
              udp0_sink.last  <= 1'b0;
              tx_count        <= tx_count + 32'd1;
              busy            <= ~fifo_empty | push;
              state           <= IDLE;
            end else begin
              byte_idx        <= next_idx;
              udp0_sink.data  <= next_byte;
              udp0_sink.last  <= (next_idx == LAST_IDX);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_status_sender.sv
// Testbench for udp_status_sender. Two instances share all stimulus: dut_a has
// heartbeats disabled, dut_h uses a 16-cycle heartbeat. A packet-level model
// predicts every output cycle; directed scenarios pin exact packet contents.
module tb_udp_status_sender;

  localparam int DEPTH = 4;
  localparam int HB_H  = 16;
  localparam int CAP_N = 128;

  typedef enum int {M_IDLE, M_LOAD, M_SEND} m_phase_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ack_req = 1'b0;
  logic [15:0] ack_seq = 16'h0000;
  logic [7:0]  ack_status = 8'h00;
  logic        ready = 1'b1;
  logic        busy_a;
  logic        busy_h;

  udp_status_sender_if sink_a ();
  udp_status_sender_if sink_h ();
  assign sink_a.ready = ready;
  assign sink_h.ready = ready;

  udp_status_sender #(.FIFO_DEPTH(DEPTH), .HEARTBEAT_CYCLES(0)) dut_a (
    .clock      (clock),
    .reset      (reset),
    .ack_req    (ack_req),
    .ack_seq    (ack_seq),
    .ack_status (ack_status),
    .udp0_sink  (sink_a),
    .busy       (busy_a)
  );

  udp_status_sender #(.FIFO_DEPTH(DEPTH), .HEARTBEAT_CYCLES(HB_H)) dut_h (
    .clock      (clock),
    .reset      (reset),
    .ack_req    (ack_req),
    .ack_seq    (ack_seq),
    .ack_status (ack_status),
    .udp0_sink  (sink_h),
    .busy       (busy_h)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Packet-level model, one slot per instance (0 = dut_a, 1 = dut_h)
  // ---------------------------------------------------------------------------
  m_phase_t    m_ph   [2];
  logic [23:0] m_q    [2][DEPTH];
  int          m_n    [2];
  logic [95:0] m_pkt  [2];
  int          m_idx  [2];
  logic [31:0] m_tx   [2];
  logic [15:0] m_drop [2];
  int          m_hb   [2];
  bit          armed = 1'b0;

  function automatic int hb_period(input int k);
    return (k == 0) ? 0 : HB_H;
  endfunction

  function automatic logic exp_valid(input int k);
    return m_ph[k] == M_SEND;
  endfunction

  function automatic logic exp_last(input int k);
    return (m_ph[k] == M_SEND) && (m_idx[k] == 11);
  endfunction

  function automatic logic [7:0] exp_data(input int k);
    return m_pkt[k][95 - 8*m_idx[k] -: 8];
  endfunction

  function automatic logic exp_busy(input int k);
    return (m_ph[k] != M_IDLE) || (m_n[k] != 0);
  endfunction

  // Advance one clock edge using the inputs that edge will sample.
  task automatic model_step(input int k);
    logic        full;
    logic        push;
    logic [15:0] s;
    logic [7:0]  st;
    if (reset) begin
      m_ph[k] = M_IDLE; m_n[k] = 0; m_tx[k] = '0; m_drop[k] = '0;
      m_hb[k] = 0; m_idx[k] = 0; m_pkt[k] = '0;
      return;
    end
    full = (m_n[k] == DEPTH);
    push = ack_req && !full;
    case (m_ph[k])
      M_IDLE: begin
        if (m_n[k] != 0) begin
          m_ph[k] = M_LOAD; m_hb[k] = 0;
        end else if (hb_period(k) != 0) begin
          if (m_hb[k] == hb_period(k) - 1) begin
            m_ph[k] = M_LOAD; m_hb[k] = 0;
          end else begin
            m_hb[k]++;
          end
        end
      end
      M_LOAD: begin
        if (m_n[k] != 0) begin
          {s, st} = m_q[k][0];
          for (int i = 0; i < DEPTH - 1; i++) m_q[k][i] = m_q[k][i+1];
          m_n[k]--;
        end else begin
          s = 16'h0000; st = 8'hFF;
        end
        m_pkt[k] = {8'h4C, 8'h43, 8'h01, st, s, m_tx[k], m_drop[k]};
        m_idx[k] = 0;
        m_ph[k]  = M_SEND;
      end
      default: begin
        if (ready) begin
          if (m_idx[k] == 11) begin
            m_tx[k] = m_tx[k] + 32'd1;
            m_ph[k] = M_IDLE;
          end else begin
            m_idx[k]++;
          end
        end
      end
    endcase
    if (push) begin
      m_q[k][m_n[k]] = {ack_seq, ack_status};
      m_n[k]++;
    end else if (ack_req && m_drop[k] != 16'hFFFF) begin
      m_drop[k] = m_drop[k] + 16'd1;
    end
  endtask

  // Packet capture of completed packets for the directed checks
  logic [95:0] cap_a [CAP_N];
  logic [95:0] cap_h [CAP_N];
  int          cap_a_n = 0;
  int          cap_h_n = 0;
  logic [95:0] cur_a = '0;
  logic [95:0] cur_h = '0;
  int          hs_a = 0;
  int          last_a = 0;

  // Compare process: outputs are stable at the falling edge, and inputs seen
  // here are exactly what the next rising edge samples.
  always @(negedge clock) begin
    if (armed) begin
      check("a.valid", sink_a.valid, exp_valid(0));
      check("a.last",  sink_a.last,  exp_last(0));
      check("a.busy",  busy_a,       exp_busy(0));
      if (exp_valid(0)) check("a.data", sink_a.data, exp_data(0));
      check("h.valid", sink_h.valid, exp_valid(1));
      check("h.last",  sink_h.last,  exp_last(1));
      check("h.busy",  busy_h,       exp_busy(1));
      if (exp_valid(1)) check("h.data", sink_h.data, exp_data(1));
    end

    if (reset) begin
      cur_a = '0;
      cur_h = '0;
    end else begin
      if (sink_a.valid && ready) begin
        cur_a = {cur_a[87:0], sink_a.data};
        hs_a++;
        if (sink_a.last) begin
          last_a++;
          if (cap_a_n < CAP_N) cap_a[cap_a_n] = cur_a;
          cap_a_n++;
          cur_a = '0;
        end
      end
      if (sink_h.valid && ready) begin
        cur_h = {cur_h[87:0], sink_h.data};
        if (sink_h.last) begin
          if (cap_h_n < CAP_N) cap_h[cap_h_n] = cur_h;
          cap_h_n++;
          cur_h = '0;
        end
      end
    end

    for (int k = 0; k < 2; k++) model_step(k);
    if (reset) armed = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_req(input logic [15:0] s, input logic [7:0] st);
    ack_req = 1'b1; ack_seq = s; ack_status = st;
    tick();
    ack_req = 1'b0;
  endtask

  task automatic wait_cap_a(input int target, input int limit, input string name);
    int t;
    t = 0;
    while (cap_a_n < target && t < limit) begin tick(); t++; end
    check(name, cap_a_n, target);
  endtask

  task automatic wait_cap_h(input int target, input int limit, input string name);
    int t;
    t = 0;
    while (cap_h_n < target && t < limit) begin tick(); t++; end
    check(name, cap_h_n, target);
  endtask

  int c0, ch0, hs0, l0, t;

  initial begin
    // Reset values
    reset = 1'b1; ready = 1'b1;
    tick();
    check("rst.valid", sink_a.valid, 1'b0);
    check("rst.last",  sink_a.last,  1'b0);
    check("rst.data",  sink_a.data,  8'h00);
    check("rst.busy",  busy_a,       1'b0);
    check("rst.h_data", sink_h.data, 8'h00);
    tick();
    reset = 1'b0;

    // Single request: valid two edges after the sampling edge
    send_req(16'h1234, 8'h02);
    check("lat.n.valid",  sink_a.valid, 1'b0);
    tick();
    check("lat.n1.valid", sink_a.valid, 1'b0);
    check("lat.n1.busy",  busy_a,       1'b1);
    tick();
    check("lat.n2.valid", sink_a.valid, 1'b1);
    check("lat.n2.data",  sink_a.data,  8'h4C);
    wait_cap_a(1, 100, "single.done");
    check("single.pkt", cap_a[0], 96'h4C43_0102_1234_0000_0000_0000);
    tick(); tick();
    send_req(16'h0BCD, 8'h00);
    wait_cap_a(2, 100, "second.done");
    check("second.pkt", cap_a[1], 96'h4C43_0100_0BCD_0000_0001_0000);

    // Backpressure: ready pattern 1,0,0 repeating
    tick(); tick();
    c0 = cap_a_n; hs0 = hs_a; l0 = last_a;
    ack_req = 1'b1; ack_seq = 16'h1234; ack_status = 8'h02;
    for (int i = 0; i < 300 && cap_a_n == c0; i++) begin
      ready = (i % 3 == 0);
      tick();
      ack_req = 1'b0;
    end
    ready = 1'b1;
    check("bp.done", cap_a_n, c0 + 1);
    check("bp.pkt", cap_a[c0], 96'h4C43_0102_1234_0000_0002_0000);
    check("bp.handshakes", hs_a - hs0, 12);
    check("bp.lasts", last_a - l0, 1);

    // Overflow: 7 back-to-back requests while the sink stalls
    tick(); tick();
    c0 = cap_a_n;
    ready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      ack_req = 1'b1; ack_seq = 16'(i); ack_status = 8'h10;
      tick();
    end
    ack_req = 1'b0;
    repeat (5) tick();
    check("ovf.busy", busy_a, 1'b1);
    check("ovf.valid_held", sink_a.valid, 1'b1);
    check("ovf.data_held", sink_a.data, 8'h4C);
    ready = 1'b1;
    wait_cap_a(c0 + 5, 300, "ovf.done");
    check("ovf.pkt1", cap_a[c0],     96'h4C43_0110_0001_0000_0003_0000);
    check("ovf.pkt2", cap_a[c0 + 1], 96'h4C43_0110_0002_0000_0004_0002);
    check("ovf.pkt5", cap_a[c0 + 4], 96'h4C43_0110_0005_0000_0007_0002);
    repeat (20) tick();
    check("ovf.no_extra", cap_a_n, c0 + 5);

    // Reset in the middle of a packet, at byte 5
    c0 = cap_a_n;
    send_req(16'h5A66, 8'h03);
    tick(); tick();
    repeat (5) tick();
    check("rmp.byte5", sink_a.data, 8'h66);
    reset = 1'b1;
    tick();
    check("rmp.valid", sink_a.valid, 1'b0);
    check("rmp.last",  sink_a.last,  1'b0);
    reset = 1'b0;
    repeat (4) tick();
    check("rmp.no_pkt", cap_a_n, c0);
    send_req(16'h0077, 8'h01);
    wait_cap_a(c0 + 1, 100, "rmp.done");
    check("rmp.pkt", cap_a[c0], 96'h4C43_0101_0077_0000_0000_0000);

    // Heartbeats on dut_h: first start, packet length, idle gap, contents
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    ch0 = cap_h_n;
    t = 0;
    while (!sink_h.valid && t < 100) begin tick(); t++; end
    check("hb.first_start", t, 17);
    t = 0;
    while (sink_h.valid && t < 100) begin tick(); t++; end
    check("hb.length", t, 12);
    t = 0;
    while (!sink_h.valid && t < 100) begin tick(); t++; end
    check("hb.gap", t, 17);
    wait_cap_h(ch0 + 2, 100, "hb.done");
    check("hb.pkt1", cap_h[ch0],     96'h4C43_01FF_0000_0000_0000_0000);
    check("hb.pkt2", cap_h[ch0 + 1], 96'h4C43_01FF_0000_0000_0001_0000);

    // Request sampled on the heartbeat expiry edge wins
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    ch0 = cap_h_n;
    repeat (15) tick();
    send_req(16'hABCD, 8'h05);
    tick();
    check("exp.valid", sink_h.valid, 1'b1);
    check("exp.data",  sink_h.data,  8'h4C);
    wait_cap_h(ch0 + 1, 100, "exp.done");
    check("exp.pkt", cap_h[ch0], 96'h4C43_0105_ABCD_0000_0000_0000);

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/udp_status_sender.md
# udp_status_sender

Transmit-side companion to the UDP panel writer. Accepts acknowledge requests from the receive/control path, queues them, and serialises each one as a fixed 12-byte status payload onto the liteeth `udp0_sink` byte stream. It also emits periodic heartbeat packets when idle. It sits between the panel-control logic and `liteeth_core` in the `clock` domain.

## Interface

Parameters:

- `FIFO_DEPTH`, default 4: request queue depth; must be a power of two, ≥2.
- `HEARTBEAT_CYCLES`, default 125000000: idle cycles between heartbeats; 0 disables heartbeats.

Ports (one clock; reset is synchronous and active-high):

- `clock` input 1: system clock (same as liteeth `sys_clock`).
- `reset` input 1: synchronous, active-high reset.
- `ack_req` input 1: single-cycle request to send an acknowledge.
- `ack_seq` input 16: sequence number to echo; sampled with `ack_req`.
- `ack_status` input 8: status code; sampled with `ack_req`; value 0xFF is reserved.
- `udp0_sink_valid` output 1: payload byte valid.
- `udp0_sink_last` output 1: marks byte 11 of the payload.
- `udp0_sink_ready` input 1: liteeth accepts the byte.
- `udp0_sink_data` output 8: payload byte.
- `busy` output 1: high in any state other than IDLE, or when the FIFO is non-empty.

## Operation

- **Request FIFO.** Each entry is {seq[15:0], status[7:0]}. A push occurs when `ack_req`=1 and the FIFO is not full, where "full" is evaluated before the edge.
  - A request arriving while full is dropped, even if a pop happens in the same cycle.
  - Each drop increments `drop_count[15:0]`, which saturates at 0xFFFF.
- **FSM.** States are IDLE, LOAD and SEND.
  - IDLE → LOAD when the FIFO is non-empty.
  - IDLE → LOAD on heartbeat expiry when the FIFO is empty. The request takes priority if both conditions hold in the same cycle.
  - LOAD, one cycle:
    - For a request: pop the FIFO head and latch seq/status.
    - For a heartbeat: latch seq=0x0000 and status=0xFF.
    - In both cases, snapshot `tx_count` and `drop_count` and set byte index = 0.
    - Then go to SEND.
  - SEND: drive the byte at the current index.
    - On `valid & ready`, the index increments.
    - On the handshake of index 11, `tx_count` increments (32-bit, wraps) and the FSM returns to IDLE.
- **Payload byte order** (multi-byte fields big-endian):
  - bytes 0–1: 0x4C, 0x43
  - byte 2: version 0x01
  - byte 3: status
  - bytes 4–5: seq
  - bytes 6–9: `tx_count` snapshot
  - bytes 10–11: `drop_count` snapshot
- **Heartbeat counter.**
  - Counts only while IDLE with the FIFO empty.
  - Clears on entering LOAD, and holds at 0 in other states.
  - Expiry is when the count equals HEARTBEAT_CYCLES-1.
- **Reset values.**
  - `udp0_sink_valid`=0, `udp0_sink_last`=0, `udp0_sink_data`=0x00, `busy`=0.
  - FIFO empty, both counters 0, heartbeat counter 0, state IDLE.
- **Reset mid-packet.** The packet is abandoned. `valid` is 0 from the cycle after the reset edge, `last` is never emitted, and `tx_count` is not incremented.

## Timing

- All outputs are registered.
- Latency: with `ack_req` sampled at edge N and the FSM in IDLE, the FIFO is non-empty after edge N. The FSM enters LOAD at edge N+1, and `udp0_sink_valid`=1 with byte 0 after edge N+2.
- Handshake rules:
  - Once `valid` is asserted, `data` and `last` hold stable until `ready`=1.
  - `valid` never deasserts mid-packet except on reset.
  - With `ready` held high, a packet occupies exactly 12 consecutive cycles.
- `udp0_sink_last`=1 only together with byte 11.
- Back-to-back packets: after the last-byte handshake the FSM takes IDLE (1 cycle) and LOAD (1 cycle), so the minimum gap is 2 cycles of `valid`=0.
- Pushes continue during SEND, so at most FIFO_DEPTH requests are held while a packet is in flight.
- `ack_req` asserted for multiple cycles counts as one request per cycle.

## Test plan

- **Single request.** Reset, `ready`=1, `ack_req` pulse with seq=0x1234, status=0x02.
  - Expected: `valid` rises 2 edges later.
  - Bytes: 4C 43 01 02 12 34 00 00 00 00 00 00, with `last` on the 12th byte.
  - A second request then reports `tx_count`=1 (bytes 6–9 = 00 00 00 01).
- **Backpressure.** Same request with `ready` toggling 1,0,0,1,… → bytes are unchanged and each is held stable while `ready`=0. Total handshakes = 12, exactly one of them with `last`.
- **Overflow.** FIFO_DEPTH=4, `ready`=0, 7 consecutive `ack_req` cycles (seq 1..7).
  - Seq 1 is in flight, seq 2–5 are queued, seq 6–7 are dropped.
  - After releasing `ready`: 5 packets with seq 1..5. Packet seq 5 reports `drop_count`=0x0002.
- **Heartbeat.** HEARTBEAT_CYCLES=16, no requests → a packet with status 0xFF and seq 0x0000 starts every 16 idle cycles plus LOAD/SEND overhead. An `ack_req` in the expiry cycle wins and sends its request packet instead.
- **Reset mid-packet.** Assert `reset` during byte 5 → `valid`=0 the next cycle and no `last`. A subsequent request reports `tx_count`=0 and `drop_count`=0.
